// File: rtl/divide.sv
// divide: iterative signed Q1.(WDTH-1) divider, z = x / y, restoring radix-2,
// one quotient bit per cycle, valid/ready handshake on both sides.
`default_nettype none

module divide #(
    parameter int WDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WDTH-1:0] x,
    input  logic [WDTH-1:0] y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WDTH-1:0] z,
    output logic            ovf
);

    localparam int             CW      = (WDTH > 2) ? $clog2(WDTH) : 1;
    localparam logic [CW-1:0]  LAST    = CW'(WDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [WDTH-1:0] MAX_POS = {1'b0, {(WDTH-1){1'b1}}};
    localparam logic [WDTH-1:0] MIN_NEG = {1'b1, {(WDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            sign;
    logic            x_neg;
    logic [WDTH-1:0] ax;
    logic [WDTH-1:0] ay;
    logic [WDTH:0]   rem;
    logic [WDTH-1:0] q;
    logic [CW-1:0]   cnt;

    logic [WDTH-1:0] abs_x;
    logic [WDTH-1:0] abs_y;
    logic [WDTH:0]   rem2;
    logic            qbit;
    logic [WDTH:0]   rem_next;

    // Magnitudes are unsigned WDTH-bit, so |-2^(WDTH-1)| is represented exactly.
    assign abs_x    = x[WDTH-1] ? -x : x;
    assign abs_y    = y[WDTH-1] ? -y : y;
    assign rem2     = {rem[WDTH-1:0], 1'b0};
    assign qbit     = (rem2 >= {1'b0, ay});
    assign rem_next = qbit ? (rem2 - {1'b0, ay}) : rem2;
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            x_neg     <= 1'b0;
            ax        <= '0;
            ay        <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            z         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign  <= x[WDTH-1] ^ y[WDTH-1];
                        x_neg <= x[WDTH-1];
                        ax    <= abs_x;
                        ay    <= abs_y;
                        rem   <= {1'b0, abs_x};
                        q     <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    if (cnt == LAST) begin
                        // All WDTH-1 quotient bits are in; pick saturated or exact result.
                        if (ay == '0) begin
                            ovf <= 1'b1;
                            z   <= x_neg ? MIN_NEG : MAX_POS;
                        end else if (ax == ay) begin
                            ovf <= ~sign;
                            z   <= sign ? MIN_NEG : MAX_POS;
                        end else if (ax > ay) begin
                            ovf <= 1'b1;
                            z   <= sign ? MIN_NEG : MAX_POS;
                        end else begin
                            ovf <= 1'b0;
                            z   <= sign ? -q : q;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem <= rem_next;
                        q   <= {q[WDTH-2:0], qbit};
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_divide.sv
// tb_divide: table-driven vectors plus backpressure and mid-operation reset sequences.
`default_nettype none

module tb_divide;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        ovf;

    int tests;
    int fails;

    divide #(.WDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
        logic               ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one operation, measure latency from the accept edge, check result, then drain.
    task automatic run_op(input logic [15:0] xi, input logic [15:0] yi,
                          input logic [15:0] ez, input logic eo, input string nm);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        x = xi;
        y = yi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'hxxxx;
        y = 16'hxxxx;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check({nm, " latency"}, lat, 32'd16);
        check({nm, " z"}, {16'd0, z}, {16'd0, ez});
        check({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " drain out_valid"}, {31'd0, out_valid}, 32'd0);
        check({nm, " drain in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int guard;
        int stray;
        logic [15:0] held_z;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;

        vecs[0]  = '{16'sd8192,   16'sd16384,  16'sd16384,  1'b0};
        vecs[1]  = '{16'sd1,      16'sd3,      16'sd10922,  1'b0};
        vecs[2]  = '{-16'sd1,     16'sd3,      -16'sd10922, 1'b0};
        vecs[3]  = '{16'sd16384,  -16'sd16384, -16'sd32768, 1'b0};
        vecs[4]  = '{16'sd16384,  16'sd16384,  16'sd32767,  1'b1};
        vecs[5]  = '{-16'sd32768, -16'sd32768, 16'sd32767,  1'b1};
        vecs[6]  = '{16'sd16384,  16'sd8192,   16'sd32767,  1'b1};
        vecs[7]  = '{-16'sd5,     16'sd0,      -16'sd32768, 1'b1};
        vecs[8]  = '{16'sd0,      16'sd0,      16'sd32767,  1'b1};
        vecs[9]  = '{16'sd7,      16'sd0,      16'sd32767,  1'b1};
        vecs[10] = '{-16'sd32768, 16'sd16384,  -16'sd32768, 1'b1};
        vecs[11] = '{-16'sd16384, -16'sd32768, 16'sd16384,  1'b0};
        vecs[12] = '{16'sd1,      -16'sd32768, -16'sd1,     1'b0};
        vecs[13] = '{16'sd32767,  -16'sd32768, -16'sd32767, 1'b0};

        // Reset state
        @(posedge clk); #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset z", {16'd0, z}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // Backpressure: hold result for 10 cycles while in_valid pulses are ignored
        @(negedge clk);
        x = 16'sd1;
        y = 16'sd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp result valid", {31'd0, out_valid}, 32'd1);
        held_z = z;
        check("bp z", {16'd0, held_z}, 32'd10922);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            x = 16'sd100;
            y = 16'sd200;
            in_valid = c[0];
            @(posedge clk); #1;
            check($sformatf("bp hold z c%0d", c), {16'd0, z}, 32'd10922);
            check($sformatf("bp hold ovf c%0d", c), {31'd0, ovf}, 32'd0);
            check($sformatf("bp hold valid c%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        check("bp z retained", {16'd0, z}, 32'd10922);

        // Reset asserted mid-DIV
        @(negedge clk);
        x = 16'sd16384;
        y = 16'sd8192;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        check("rst mid in_ready", {31'd0, in_ready}, 32'd1);
        check("rst mid z", {16'd0, z}, 32'd0);
        check("rst mid ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check("rst no stale result", stray, 32'd0);
        run_op(-16'sd8192, 16'sd16384, -16'sd16384, 1'b0, "post-reset op");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
